// File: rtl/vga_pkg.sv
// Shared constants, state type and helpers for the VGA sync monitor.
package vga_pkg;

  // 640x480@60 timing as seen from a 100 MHz system clock (4 clk per pixel).
  localparam int H_TOTAL_CLK = 3200;
  localparam int H_SYNC_CLK  = 384;
  localparam int V_TOTAL     = 525;
  localparam int V_SYNC      = 2;

  // Width of every measurement counter.
  localparam int CNT_W = 16;

  // Monitor state: no usable hsync, measuring frames, timing confirmed.
  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_e;

  // True when value lies within nominal +/- tol.
  function automatic logic in_tol(input int value, input int nominal, input int tol);
    int diff;
    diff = value - nominal;
    return (diff <= tol) && (diff >= -tol);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: brings one raw sync pin into the clk domain, normalises it to
// active-high and produces registered level, rise and fall strobes.
// A pin change shows up on level_o/rise_o/fall_o three clk edges later.
module sync_edge #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic level_q;
  logic rise_q;
  logic fall_q;
  logic level_d;

  // Active-high version of the synchronised pin.
  assign level_d = sync_q ^ ACTIVE_LOW;

  // Two-flop synchronizer followed by the edge-detect register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the synchronizer resets to the idle pin level, so leaving reset
      // with an inactive pin cannot produce a false edge.
      meta_q  <= ACTIVE_LOW;
      sync_q  <= ACTIVE_LOW;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep meta_q -> sync_q a genuine
      // two-stage chain; blocking ones would collapse it into a single flop.
      meta_q  <= pin_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: measures line period, hsync width, lines per frame and
// vsync width of an incoming VGA sync pair, checks each frame against the
// nominal timing, and reports lock, per-frame errors and loss of hsync.
module vga_sync_monitor #(
  parameter int H_TOTAL_CLK     = vga_pkg::H_TOTAL_CLK,
  parameter int H_SYNC_CLK      = vga_pkg::H_SYNC_CLK,
  parameter int V_TOTAL         = vga_pkg::V_TOTAL,
  parameter int V_SYNC          = vga_pkg::V_SYNC,
  parameter int H_TOL           = 4,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int LOCK_FRAMES     = 2,
  parameter int CNT_W           = vga_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hsync,
  input  logic             vsync,
  output logic [CNT_W-1:0] h_period,
  output logic [CNT_W-1:0] h_pulse,
  output logic [CNT_W-1:0] v_lines,
  output logic [CNT_W-1:0] v_pulse,
  output logic             frame_done,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] frame_count
);

  import vga_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_CNT    = CNT_W'(2 * H_TOTAL_CLK);
  localparam logic [CNT_W-1:0] LOCK_CNT   = CNT_W'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0] V_TOT_CNT  = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] V_SYNC_CNT = CNT_W'(V_SYNC);

  // Conditioned sync strobes.
  logic hs_lvl, hs_rise, hs_fall;
  logic vs_lvl, vs_rise, vs_fall;

  // Horizontal measurement.
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] hw_q, hw_d;
  logic [CNT_W-1:0] h_period_q, h_period_d;
  logic [CNT_W-1:0] h_pulse_q, h_pulse_d;
  logic             h_valid_q, h_valid_d;

  // Line / frame measurement.
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic [CNT_W-1:0] vw_q, vw_d;
  logic [CNT_W-1:0] v_lines_q, v_lines_d;
  logic [CNT_W-1:0] v_pulse_q, v_pulse_d;
  logic             v_valid_q, v_valid_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;

  // Checking and reporting.
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic             tmo_fired_q, tmo_fired_d;
  logic             err_q, err_d;
  logic             frame_done_q, frame_done_d;
  logic             timeout;
  logic             frame_ok;
  logic             check_fail;

  mon_state_e state_q, state_d;

  sync_edge #(
    .ACTIVE_LOW (SYNC_ACTIVE_LOW)
  ) u_hs_edge (
    .clk     (clk),
    .rst_n   (reset),
    .pin_i   (hsync),
    .level_o (hs_lvl),
    .rise_o  (hs_rise),
    .fall_o  (hs_fall)
  );

  sync_edge #(
    .ACTIVE_LOW (SYNC_ACTIVE_LOW)
  ) u_vs_edge (
    .clk     (clk),
    .rst_n   (reset),
    .pin_i   (vsync),
    .level_o (vs_lvl),
    .rise_o  (vs_rise),
    .fall_o  (vs_fall)
  );

  // Measurement counters, latches, frame check and timeout (next-state logic).
  always_comb begin
    // NOTE: every _d signal takes its hold value first; any path that skips an
    // assignment would otherwise infer a latch.
    hcnt_d        = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + ONE;
    hw_d          = hw_q;
    h_period_d    = h_period_q;
    h_pulse_d     = h_pulse_q;
    h_valid_d     = h_valid_q;
    lcnt_d        = lcnt_q;
    vw_d          = vw_q;
    v_lines_d     = v_lines_q;
    v_pulse_d     = v_pulse_q;
    v_valid_d     = v_valid_q;
    frame_count_d = frame_count_q;
    good_cnt_d    = good_cnt_q;
    tmo_fired_d   = tmo_fired_q;
    frame_ok      = 1'b1;
    check_fail    = 1'b0;

    // A lost hsync is reported once, then stays quiet until hsync returns.
    timeout = (hcnt_q >= TMO_CNT) && !tmo_fired_q && !hs_rise;

    // Line period: time between consecutive hsync rises.
    if (hs_rise) begin
      if (h_valid_q) begin
        h_period_d = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + ONE;
      end
      hcnt_d      = '0;
      h_valid_d   = 1'b1;
      tmo_fired_d = 1'b0;
      if (lcnt_q != CNT_MAX) begin
        lcnt_d = lcnt_q + ONE;
      end
    end

    // hsync width: clk cycles with hs high, captured on the falling edge.
    if (hs_fall) begin
      h_pulse_d = hw_q;
      hw_d      = '0;
    end else if (hs_lvl && (hw_q != CNT_MAX)) begin
      hw_d = hw_q + ONE;
    end

    // vsync width: lines started while vs is high, captured on the falling edge.
    if (vs_fall) begin
      v_pulse_d = vw_q;
      vw_d      = '0;
    end else if (vs_lvl && hs_rise && (vw_q != CNT_MAX)) begin
      vw_d = vw_q + ONE;
    end

    // Frame end: latch line count and judge the frame just completed.
    if (vs_rise) begin
      if (v_valid_q) begin
        v_lines_d = lcnt_q;
        frame_ok  = in_tol(int'(h_period_d), H_TOTAL_CLK, H_TOL) &&
                    in_tol(int'(h_pulse_d), H_SYNC_CLK, H_TOL) &&
                    (v_lines_d == V_TOT_CNT) && (v_pulse_d == V_SYNC_CNT) &&
                    (h_period_d != CNT_MAX) && (h_pulse_d != CNT_MAX) &&
                    (v_lines_d != CNT_MAX) && (v_pulse_d != CNT_MAX);
        check_fail = !frame_ok;
        if (check_fail) begin
          good_cnt_d = '0;
        end else if (good_cnt_q != LOCK_CNT) begin
          good_cnt_d = good_cnt_q + ONE;
        end
      end
      // An hsync rise in the same clk is the first line of the new frame.
      lcnt_d        = hs_rise ? ONE : '0;
      v_valid_d     = 1'b1;
      frame_count_d = frame_count_q + ONE;
    end

    if (timeout) begin
      good_cnt_d  = '0;
      h_valid_d   = 1'b0;
      v_valid_d   = 1'b0;
      tmo_fired_d = 1'b1;
    end

    err_d        = check_fail || timeout;
    frame_done_d = vs_rise;
  end

  // Measurement and reporting registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt_q        <= '0;
      hw_q          <= '0;
      h_period_q    <= '0;
      h_pulse_q     <= '0;
      h_valid_q     <= 1'b0;
      lcnt_q        <= '0;
      vw_q          <= '0;
      v_lines_q     <= '0;
      v_pulse_q     <= '0;
      v_valid_q     <= 1'b0;
      frame_count_q <= '0;
      good_cnt_q    <= '0;
      tmo_fired_q   <= 1'b0;
      err_q         <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      hw_q          <= hw_d;
      h_period_q    <= h_period_d;
      h_pulse_q     <= h_pulse_d;
      h_valid_q     <= h_valid_d;
      lcnt_q        <= lcnt_d;
      vw_q          <= vw_d;
      v_lines_q     <= v_lines_d;
      v_pulse_q     <= v_pulse_d;
      v_valid_q     <= v_valid_d;
      frame_count_q <= frame_count_d;
      good_cnt_q    <= good_cnt_d;
      tmo_fired_q   <= tmo_fired_d;
      err_q         <= err_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Monitor state transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      UNSYNC:  if (vs_rise && h_valid_q) state_d = MEASURE;
      MEASURE: if (good_cnt_d == LOCK_CNT) state_d = LOCKED;
      LOCKED:  if (check_fail) state_d = MEASURE;
      default: state_d = UNSYNC;
    endcase
    if (timeout) begin
      state_d = UNSYNC;
    end
  end

  // Monitor state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= UNSYNC;
    end else begin
      state_q <= state_d;
    end
  end

  assign h_period    = h_period_q;
  assign h_pulse     = h_pulse_q;
  assign v_lines     = v_lines_q;
  assign v_pulse     = v_pulse_q;
  assign frame_done  = frame_done_q;
  assign locked      = (good_cnt_q == LOCK_CNT);
  assign err         = err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down raster
// (80 clk lines, 12 clk hsync, 12 lines per frame, 2 line vsync) so a
// complete scenario set stays short. A second instance runs with
// active-high polarity on the inverted pins.
module tb_vga_sync_monitor;

  import vga_pkg::*;

  localparam int HT  = 80;
  localparam int HS  = 12;
  localparam int VT  = 12;
  localparam int VS  = 2;
  localparam int TOL = 4;
  localparam int CW  = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic hs_act = 1'b0;
  logic vs_act = 1'b0;

  logic hsync_n, vsync_n;
  assign hsync_n = ~hs_act;
  assign vsync_n = ~vs_act;

  logic [CW-1:0] h_period, h_pulse, v_lines, v_pulse, frame_count;
  logic          frame_done, locked, err;
  logic [CW-1:0] h_period_hi, h_pulse_hi, v_lines_hi, v_pulse_hi, frame_count_hi;
  logic          frame_done_hi, locked_hi, err_hi;

  vga_sync_monitor #(
    .H_TOTAL_CLK(HT), .H_SYNC_CLK(HS), .V_TOTAL(VT), .V_SYNC(VS),
    .H_TOL(TOL), .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync_n), .vsync(vsync_n),
    .h_period(h_period), .h_pulse(h_pulse), .v_lines(v_lines), .v_pulse(v_pulse),
    .frame_done(frame_done), .locked(locked), .err(err), .frame_count(frame_count)
  );

  vga_sync_monitor #(
    .H_TOTAL_CLK(HT), .H_SYNC_CLK(HS), .V_TOTAL(VT), .V_SYNC(VS),
    .H_TOL(TOL), .SYNC_ACTIVE_LOW(1'b0), .LOCK_FRAMES(2), .CNT_W(CW)
  ) dut_hi (
    .clk(clk), .reset(reset), .hsync(hs_act), .vsync(vs_act),
    .h_period(h_period_hi), .h_pulse(h_pulse_hi), .v_lines(v_lines_hi),
    .v_pulse(v_pulse_hi), .frame_done(frame_done_hi), .locked(locked_hi),
    .err(err_hi), .frame_count(frame_count_hi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;
  int err_cnt  = 0;
  int err_cnt_hi = 0;
  int fd_cnt   = 0;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (err)        err_cnt++;
    if (err_hi)     err_cnt_hi++;
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive n_lines raster lines starting at line 0 of a frame; line long_idx
  // lasts long_len clk instead of HT.
  task automatic drive_lines(input int n_lines, input int long_idx, input int long_len);
    for (int l = 0; l < n_lines; l++) begin
      int len;
      len = (l == long_idx) ? long_len : HT;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        hs_act = (c < HS);
        vs_act = (l < VS);
      end
    end
  endtask

  task automatic drive_frame();
    drive_lines(VT, -1, HT);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hs_act = 1'b0;
      vs_act = 1'b0;
    end
  endtask

  int e0, fd0;

  initial begin
    // Reset state.
    #1;
    check("rst_h_period", 32'(h_period), 0);
    check("rst_v_lines", 32'(v_lines), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(err), 0);
    check("rst_state", 32'(dut.state_q), 32'(UNSYNC));
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Nominal timing: lock after the third vsync rise.
    e0  = err_cnt;
    fd0 = fd_cnt;
    drive_frame();
    drive_frame();
    check("nom_locked_after_2", 32'(locked), 0);
    drive_frame();
    check("nom_locked_after_3", 32'(locked), 1);
    check("nom_state", 32'(dut.state_q), 32'(LOCKED));
    drive_frame();
    check("nom_h_period", 32'(h_period), HT);
    check("nom_h_pulse", 32'(h_pulse), HS);
    check("nom_v_lines", 32'(v_lines), VT);
    check("nom_v_pulse", 32'(v_pulse), VS);
    check("nom_frame_count", 32'(frame_count), 4);
    check("nom_frame_done_pulses", 32'(fd_cnt - fd0), 4);
    check("nom_no_err", 32'(err_cnt - e0), 0);

    // Same raster on the active-high instance.
    check("hi_h_period", 32'(h_period_hi), HT);
    check("hi_h_pulse", 32'(h_pulse_hi), HS);
    check("hi_v_lines", 32'(v_lines_hi), VT);
    check("hi_v_pulse", 32'(v_pulse_hi), VS);
    check("hi_locked", 32'(locked_hi), 1);
    check("hi_no_err", 32'(err_cnt_hi), 0);

    // Last line at +TOL is still accepted.
    e0 = err_cnt;
    drive_lines(VT, VT - 1, HT + TOL);
    drive_frame();
    check("tol_edge_no_err", 32'(err_cnt - e0), 0);
    check("tol_edge_locked", 32'(locked), 1);

    // Last line of +10 clk fails the next frame check, then relocks.
    e0 = err_cnt;
    drive_lines(VT, VT - 1, HT + 10);
    drive_frame();
    check("long_err_pulse", 32'(err_cnt - e0), 1);
    check("long_locked_drop", 32'(locked), 0);
    check("long_state", 32'(dut.state_q), 32'(MEASURE));
    check("long_h_period_recovers", 32'(h_period), HT);
    drive_frame();
    check("relock_after_1", 32'(locked), 0);
    drive_frame();
    check("relock_after_2", 32'(locked), 1);
    check("relock_err_total", 32'(err_cnt - e0), 1);

    // hsync lost for longer than two line periods: one err only.
    e0 = err_cnt;
    idle(5 * HT);
    check("tmo_single_err", 32'(err_cnt - e0), 1);
    check("tmo_locked", 32'(locked), 0);
    check("tmo_state", 32'(dut.state_q), 32'(UNSYNC));

    // Recovery after timeout: first frame unchecked, lock after two checks.
    e0 = err_cnt;
    drive_frame();
    check("tmo_rec_state_1", 32'(dut.state_q), 32'(UNSYNC));
    drive_frame();
    check("tmo_rec_state_2", 32'(dut.state_q), 32'(MEASURE));
    drive_frame();
    check("tmo_rec_locked", 32'(locked), 1);
    check("tmo_rec_no_err", 32'(err_cnt - e0), 0);

    // Reset pulse in the middle of a frame.
    fork
      drive_frame();
      begin
        repeat (6 * HT + 40) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_h_period", 32'(h_period), 0);
        check("mid_rst_h_pulse", 32'(h_pulse), 0);
        check("mid_rst_v_lines", 32'(v_lines), 0);
        check("mid_rst_v_pulse", 32'(v_pulse), 0);
        check("mid_rst_frame_count", 32'(frame_count), 0);
        check("mid_rst_locked", 32'(locked), 0);
        check("mid_rst_state", 32'(dut.state_q), 32'(UNSYNC));
        repeat (3) @(negedge clk);
        reset = 1'b1;
      end
    join
    e0 = err_cnt;
    drive_frame();
    drive_frame();
    check("post_rst_not_locked", 32'(locked), 0);
    drive_frame();
    check("post_rst_locked", 32'(locked), 1);
    check("post_rst_no_err", 32'(err_cnt - e0), 0);
    check("post_rst_frame_count", 32'(frame_count), 3);
    check("post_rst_v_lines", 32'(v_lines), VT);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receiving end of the VGA sync interface. Samples the hsync/vsync pins driven by the display timing generator and measures line period, hsync width, lines per frame and vsync width in system clocks and lines.
- Checks the measurements against the nominal 640x480@60 timing and reports lock and errors.
- Used as an on-chip monitor behind the timing generator and as a self-checking element in system simulation.

Parameters:
- H_TOTAL_CLK, 3200, nominal clk cycles per line (800 pixels x 4 clk at 100 MHz)
- H_SYNC_CLK, 384, nominal clk cycles hsync asserted
- V_TOTAL, 525, nominal lines per frame
- V_SYNC, 2, nominal lines vsync asserted
- H_TOL, 4, allowed +/- deviation in clk cycles for both horizontal measurements
- SYNC_ACTIVE_LOW, 1, input polarity: 1 means active-low syncs
- LOCK_FRAMES, 2, consecutive good frames required to assert locked
- CNT_W, 16, width of all measurement counters

Ports:
- clk, input, 1, system clock
- reset, input, 1, asynchronous active-low reset
- hsync, input, 1, raw horizontal sync; asynchronous to clk
- vsync, input, 1, raw vertical sync; asynchronous to clk
- h_period, output, CNT_W, last measured line period in clk
- h_pulse, output, CNT_W, last measured hsync width in clk
- v_lines, output, CNT_W, last measured lines per frame
- v_pulse, output, CNT_W, last measured vsync width in lines
- frame_done, output, 1, one-cycle pulse on each vsync assert edge
- locked, output, 1, timing matches nominal
- err, output, 1, one-cycle pulse on a failed frame check or timeout
- frame_count, output, CNT_W, frames seen since reset; wraps

Behaviour:
- Reset: all outputs and internal counters go to 0, and the valid flags clear.
- Input conditioning:
  - Two-flop synchronizer per input, then XOR with SYNC_ACTIVE_LOW, giving active-high hs/vs.
  - A rise/fall detect register follows, so an edge is visible 3 clk after the pin change.
- Horizontal measurement:
  - hcnt increments every clk and saturates at all-ones.
  - On an hs rise: latch h_period = hcnt+1 (only if h_valid), reset hcnt to 0, set h_valid.
  - hw counts clk while hs is high and latches into h_pulse on the hs fall.
- Line counting:
  - lcnt increments on each hs rise and saturates.
  - vw counts hs rises while vs is high and latches into v_pulse on the vs fall.
- Frame end (vs rise):
  - If v_valid: latch v_lines = lcnt, then run the frame check.
  - Always: clear lcnt, set v_valid, increment frame_count, pulse frame_done.
  - If an hs rise coincides with a vs rise, that hs rise counts toward the new frame: lcnt becomes 1.
- Frame check (uses the latched values, including the v_lines latched this cycle):
  - |h_period - H_TOTAL_CLK| <= H_TOL
  - |h_pulse - H_SYNC_CLK| <= H_TOL
  - v_lines == V_TOTAL
  - v_pulse == V_SYNC
  - A saturated counter always fails.
  - Pass increments good_cnt, saturating at LOCK_FRAMES; locked = (good_cnt == LOCK_FRAMES).
  - Fail clears good_cnt, deasserts locked the next cycle, and pulses err.
- Timeout: if hcnt reaches 2*H_TOTAL_CLK with no hs rise:
  - pulse err once, clear locked, good_cnt, h_valid and v_valid;
  - no further err until the next hs rise.
- State machine with states UNSYNC, MEASURE, LOCKED:
  - UNSYNC goes to MEASURE on the first vs rise with h_valid set.
  - MEASURE goes to LOCKED when good_cnt reaches LOCK_FRAMES.
  - LOCKED goes back to MEASURE on a failed check.
  - Any state goes to UNSYNC on timeout.
- Reset asserted mid-frame returns everything to reset values immediately (asynchronous).
- The first frame after reset is never checked and never raises err.

Decomposition:
- Package vga_pkg holds:
  - the 640x480@60 constants: H_TOTAL_CLK, H_SYNC_CLK, V_TOTAL, V_SYNC;
  - CNT_W;
  - the monitor state enum: UNSYNC, MEASURE, LOCKED.
- Sub-module sync_edge handles one input: 2FF synchronizer, polarity XOR, and registered rise/fall outputs. It is instantiated twice.

Test Plan:
- Nominal 640x480 sync (hsync low 384 clk of 3200; vsync low 2 of 525 lines) for 4 frames -> h_period=3200, h_pulse=384, v_lines=525, v_pulse=2; locked asserted after the 3rd vs rise; no err.
- Lock, then one line of 3210 clk -> err pulse on that frame's vs rise; locked drops; relocks after 2 clean frames.
- Lock, then hsync held inactive for 6400 clk -> exactly one err pulse at hcnt=6400; locked=0; state UNSYNC.
- hs rise and vs rise in the same clk -> frame_done pulses; next v_lines=525, no off-by-one.
- SYNC_ACTIVE_LOW=0 with inverted stimulus -> same measurements and lock as the nominal scenario.
- Reset driven low mid-frame for 3 clk -> all outputs 0 immediately; first frame after release gives no err.
